dvi_timing_monitor: RTL and testbench
=====================================

# dvi_timing_monitor

Receive-side counterpart to the DVI timing generator. Samples `hsync`, `vsync` and `ve` on the pixel clock, measures the frame geometry and locks to it. Once locked, it emits per-pixel coordinates and line/frame strobes to downstream capture and checking logic. It sits on the input of the HDMI capture path and serves as a self-checker on the generator output in simulation.

## Interface
- `CNT_W`, 12: width of all horizontal and vertical counters and measurements.
- `HS_POL`, 1: hsync active level (1 = active-high).
- `VS_POL`, 1: vsync active level.
- `clock` in 1: pixel clock; every input is sampled here.
- `reset` in 1: synchronous, active-low (0 = reset).
- `hsync` in 1: horizontal sync from the source.
- `vsync` in 1: vertical sync.
- `ve` in 1: video enable (active-high; data valid).
- `pixel_valid` out 1: registered copy of `ve`, aligned with `x`/`y`; forced 0 while not locked.
- `x` out CNT_W: active pixel index within the line.
- `y` out CNT_W: active line index within the frame.
- `line_start` out 1: 1-cycle pulse on the first active pixel of each line (locked only).
- `frame_start` out 1: 1-cycle pulse on pixel (0,0) (locked only).
- `locked` out 1: geometry stable.
- `error` out 1: 1-cycle pulse when a measured frame differs from the locked geometry.
- `h_total`, `h_active`, `v_total`, `v_active` out CNT_W each: locked geometry.

## Operation
- Input stage:
  - `hsync`/`vsync`/`ve` pass through one register stage.
  - Sync is normalised by `HS_POL`/`VS_POL`.
  - The leading edge is "asserted now, deasserted last cycle".
- Measurement counters, restarted at each leading edge:
  - hcnt: clocks between hsync leading edges; the value latched at the edge is that line's total.
  - acnt: `ve`-high clocks in the line.
  - vcnt: hsync leading edges between vsync leading edges.
  - lcnt: lines containing at least one `ve`-high cycle.
- Saturation: all counters saturate at 2^CNT_W−1. A saturated counter marks the current frame invalid; an invalid frame never matches.
- Line consistency: every line in a frame must have the same hcnt; each active line must have the same acnt. Any difference marks the frame invalid.
- FSM states: IDLE, MEASURE, VERIFY, LOCKED.
  - IDLE: on the first vsync leading edge, go to MEASURE.
  - MEASURE: on the next vsync edge, store the candidate geometry and go to VERIFY. An invalid frame stays in MEASURE.
  - VERIFY: on the next vsync edge, if the frame is valid and equal to the candidate, commit it to the `h_*`/`v_*` outputs, assert `locked` and go to LOCKED. Otherwise reload the candidate from this frame and stay in VERIFY.
  - LOCKED: at every vsync edge, compare the frame just ended. On mismatch or invalid frame: pulse `error`, deassert `locked`, and go to MEASURE, using this frame as the new candidate source.
- Coordinates:
  - `x`: 0 on each `ve` rising edge, +1 per `ve`-high cycle.
  - `y`: 0 on the first `ve` rising edge after a vsync leading edge, +1 on each later `ve` rising edge.
  - When `ve` is low, `x` and `y` hold their values.
- Simultaneous hsync and vsync edges: the vsync frame closes first. The line count includes that hsync edge, so a frame of N lines reports `v_total` = N.

## Timing
- Pin-to-output latency: `x`, `y`, `pixel_valid`, `line_start` and `frame_start` appear 2 clocks after `ve` at the pin.
- `locked`, `error` and the geometry outputs update 2 clocks after the vsync leading edge at the pin.
- Lock time: lock occurs at the 3rd vsync edge after reset when the first two frames are good.
- Reset values: all outputs 0; FSM in IDLE; counters 0; candidate 0.
- Reset asserted mid-frame clears state on the next clock edge. The monitor must see a fresh vsync edge before measuring again.
- A sync asserted continuously from reset release is not an edge.

## Structure
- Package `dvi_timing_pkg`: FSM state enum, a `dvi_geom_t` struct (`h_total`, `h_active`, `v_total`, `v_active`), and a default `CNT_W`.
- Sub-module `dvi_sync_edge`: input register, polarity normalisation and leading-edge detect. Instanced once each for hsync and vsync. `ve` uses the same module with polarity 1.
- The FSM, counters and compare logic live in the top module.

## Test plan
- Geometry h_total=20, h_active=12, v_total=10, v_active=6, 3 frames → `locked` rises 2 clocks after the 3rd vsync edge; outputs read 20/12/10/6; `error` stays 0.
- Locked, then frame 4 has h_total=21 → `error` pulses once at frame end, `locked` falls. Frames 5 and 6 at 21 → relock with `h_total`=21.
- Locked: `frame_start` at (0,0) each frame. `line_start` 6 times per frame. `x` runs 0..11; `y` runs 0..5; `pixel_valid` count is 72 per frame.
- `HS_POL`=0, `VS_POL`=0 with inverted syncs → same lock and geometry as the first scenario.
- `reset` low for 1 clock mid-frame while locked → next clock all outputs 0. Relock happens at the 3rd subsequent vsync edge.
- hsync held inactive for 5000 clocks (CNT_W=12) → hcnt saturates, the frame is invalid, no lock. Normal syncs afterwards → lock after 2 good frames.

Source files
------------

// File: rtl/dvi_timing_pkg.sv
// rtl/dvi_timing_pkg.sv - shared types and constants for the DVI timing monitor
package dvi_timing_pkg;

  localparam int DEF_CNT_W = 12;
  // Geometry fields are stored at this width; CNT_W must not exceed it.
  localparam int GEOM_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_VERIFY,
    ST_LOCKED
  } mon_state_t;

  typedef struct packed {
    logic [GEOM_W-1:0] h_total;
    logic [GEOM_W-1:0] h_active;
    logic [GEOM_W-1:0] v_total;
    logic [GEOM_W-1:0] v_active;
  } dvi_geom_t;

endpackage

// File: rtl/dvi_timing_monitor_if.sv
// rtl/dvi_timing_monitor_if.sv - raw DVI sync/enable bundle from a video source
interface dvi_timing_monitor_if;

  logic hsync;
  logic vsync;
  logic ve;

  modport master (output hsync, output vsync, output ve);
  modport slave  (input hsync, input vsync, input ve);

endinterface

// File: rtl/dvi_sync_edge.sv
// rtl/dvi_sync_edge.sv - input register, polarity normalisation, leading-edge detect
module dvi_sync_edge #(
  parameter bit POL     = 1'b1,
  parameter bit RST_LVL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic i_sync,
  output logic o_level,
  output logic o_edge
);

  logic r_level;
  logic r_level_d;

  // Resetting to RST_LVL=1 means a sync already asserted at reset release is not an edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_level   <= RST_LVL;
      r_level_d <= RST_LVL;
    end else begin
      r_level   <= (i_sync == POL);
      r_level_d <= r_level;
    end
  end

  assign o_level = r_level;
  assign o_edge  = r_level & ~r_level_d;

endmodule

// File: rtl/dvi_timing_monitor.sv
// rtl/dvi_timing_monitor.sv - measures DVI frame geometry, locks to it, emits pixel coordinates
module dvi_timing_monitor
  import dvi_timing_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  dvi_timing_monitor_if.slave  vid,
  output logic                 pixel_valid,
  output logic [CNT_W-1:0]     x,
  output logic [CNT_W-1:0]     y,
  output logic                 line_start,
  output logic                 frame_start,
  output logic                 locked,
  output logic                 error,
  output logic [CNT_W-1:0]     h_total,
  output logic [CNT_W-1:0]     h_active,
  output logic [CNT_W-1:0]     v_total,
  output logic [CNT_W-1:0]     v_active
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != CNT_MAX)) ? v + CNT_ONE : v;
  endfunction

  logic w_h_edge, w_h_lvl, w_v_edge, w_v_lvl, w_ve, w_ve_rise;
  logic w_sync_lvl_unused;

  dvi_sync_edge #(.POL(HS_POL), .RST_LVL(1'b1)) u_hs_edge (
    .clock(clock), .reset(reset), .i_sync(vid.hsync), .o_level(w_h_lvl), .o_edge(w_h_edge));
  dvi_sync_edge #(.POL(VS_POL), .RST_LVL(1'b1)) u_vs_edge (
    .clock(clock), .reset(reset), .i_sync(vid.vsync), .o_level(w_v_lvl), .o_edge(w_v_edge));
  dvi_sync_edge #(.POL(1'b1), .RST_LVL(1'b0)) u_ve_edge (
    .clock(clock), .reset(reset), .i_sync(vid.ve), .o_level(w_ve), .o_edge(w_ve_rise));

  assign w_sync_lvl_unused = w_h_lvl ^ w_v_lvl;

  logic [CNT_W-1:0] r_hcnt, r_acnt, r_vcnt, r_lcnt, r_htot_ref, r_aact_ref;
  logic             r_href_set, r_aref_set, r_invalid;
  mon_state_t       r_state, w_state_nx;
  dvi_geom_t        r_cand, r_geom, w_frame;
  logic             r_locked, r_error;
  logic             w_load_cand, w_commit, w_err;
  logic [CNT_W-1:0] r_x, r_y;
  logic             r_vfirst, r_pv, r_ls, r_fs;

  logic             w_line_act, w_sat, w_line_bad, w_frame_valid;
  logic [CNT_W-1:0] w_htot, w_aact, w_vtot, w_vact;

  // A frame closing on a coincident hsync edge includes that final line.
  assign w_line_act = (r_acnt != '0);
  assign w_sat      = (r_hcnt == CNT_MAX) | (r_acnt == CNT_MAX) |
                      (r_vcnt == CNT_MAX) | (r_lcnt == CNT_MAX);
  assign w_line_bad = w_h_edge & ((r_href_set & (r_hcnt != r_htot_ref)) |
                                  (w_line_act & r_aref_set & (r_acnt != r_aact_ref)));
  assign w_frame_valid = ~(r_invalid | w_sat | w_line_bad);
  assign w_htot = r_href_set ? r_htot_ref : (w_h_edge ? r_hcnt : '0);
  assign w_aact = r_aref_set ? r_aact_ref : ((w_h_edge && w_line_act) ? r_acnt : '0);
  assign w_vtot = sat_inc(r_vcnt, w_h_edge);
  assign w_vact = sat_inc(r_lcnt, w_h_edge & w_line_act);

  always_comb begin
    w_frame = '{h_total:  GEOM_W'(w_htot), h_active: GEOM_W'(w_aact),
                v_total:  GEOM_W'(w_vtot), v_active: GEOM_W'(w_vact)};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_hcnt     <= '0;
      r_acnt     <= '0;
      r_vcnt     <= '0;
      r_lcnt     <= '0;
      r_htot_ref <= '0;
      r_aact_ref <= '0;
      r_href_set <= 1'b0;
      r_aref_set <= 1'b0;
      r_invalid  <= 1'b0;
    end else begin
      r_hcnt <= w_h_edge ? CNT_ONE : sat_inc(r_hcnt, 1'b1);
      r_acnt <= w_h_edge ? CNT_W'(w_ve) : sat_inc(r_acnt, w_ve);
      if (w_v_edge) begin
        r_vcnt     <= '0;
        r_lcnt     <= '0;
        r_href_set <= 1'b0;
        r_aref_set <= 1'b0;
        r_invalid  <= 1'b0;
      end else begin
        r_vcnt <= w_vtot;
        r_lcnt <= w_vact;
        if (w_sat || w_line_bad) r_invalid <= 1'b1;
        if (w_h_edge && !r_href_set) begin
          r_htot_ref <= r_hcnt;
          r_href_set <= 1'b1;
        end
        if (w_h_edge && w_line_act && !r_aref_set) begin
          r_aact_ref <= r_acnt;
          r_aref_set <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_load_cand = 1'b0;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    if (w_v_edge) begin
      case (r_state)
        ST_IDLE: w_state_nx = ST_MEASURE;
        ST_MEASURE: begin
          if (w_frame_valid) begin
            w_load_cand = 1'b1;
            w_state_nx  = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (w_frame_valid && (w_frame == r_cand)) begin
            w_commit   = 1'b1;
            w_state_nx = ST_LOCKED;
          end else begin
            w_load_cand = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!w_frame_valid || (w_frame != r_geom)) begin
            w_err       = 1'b1;
            w_load_cand = 1'b1;
            w_state_nx  = ST_MEASURE;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cand   <= '0;
      r_geom   <= '0;
      r_locked <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_locked <= (w_state_nx == ST_LOCKED);
      r_error  <= w_err;
      if (w_load_cand) r_cand <= w_frame;
      if (w_commit) r_geom <= w_frame;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_vfirst <= 1'b0;
      r_pv     <= 1'b0;
      r_ls     <= 1'b0;
      r_fs     <= 1'b0;
    end else begin
      if (w_v_edge) r_vfirst <= 1'b1;
      else if (w_ve_rise) r_vfirst <= 1'b0;
      if (w_ve_rise) r_x <= '0;
      else if (w_ve) r_x <= r_x + CNT_ONE;
      if (w_ve_rise) r_y <= r_vfirst ? '0 : r_y + CNT_ONE;
      r_pv <= r_locked & w_ve;
      r_ls <= r_locked & w_ve_rise;
      r_fs <= r_locked & w_ve_rise & r_vfirst;
    end
  end

  assign pixel_valid = r_pv;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_ls;
  assign frame_start = r_fs;
  assign locked      = r_locked;
  assign error       = r_error;
  assign h_total     = r_geom.h_total[CNT_W-1:0];
  assign h_active    = r_geom.h_active[CNT_W-1:0];
  assign v_total     = r_geom.v_total[CNT_W-1:0];
  assign v_active    = r_geom.v_active[CNT_W-1:0];

endmodule

// File: tb/tb_dvi_timing_monitor.sv
// tb/tb_dvi_timing_monitor.sv - self-checking bench for dvi_timing_monitor
module tb_dvi_timing_monitor;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        ls;
    logic        fs;
  } pix_t;

  logic clock;
  logic reset;

  dvi_timing_monitor_if vid_a ();
  dvi_timing_monitor_if vid_b ();

  logic        pv_a, ls_a, fs_a, lk_a, er_a;
  logic [11:0] x_a, y_a, ht_a, ha_a, vt_a, va_a;
  logic        pv_b, ls_b, fs_b, lk_b, er_b;
  logic [11:0] x_b, y_b, ht_b, ha_b, vt_b, va_b;

  dvi_timing_monitor u_dut_a (
    .clock(clock), .reset(reset), .vid(vid_a),
    .pixel_valid(pv_a), .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a),
    .locked(lk_a), .error(er_a), .h_total(ht_a), .h_active(ha_a),
    .v_total(vt_a), .v_active(va_a));

  dvi_timing_monitor #(.HS_POL(1'b0), .VS_POL(1'b0)) u_dut_b (
    .clock(clock), .reset(reset), .vid(vid_b),
    .pixel_valid(pv_b), .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b),
    .locked(lk_b), .error(er_b), .h_total(ht_b), .h_active(ha_b),
    .v_total(vt_b), .v_active(va_b));

  int   vectors;
  int   miscompares;
  bit   exp_locked;
  pix_t sb_q[$];
  int   pv_cnt, ls_cnt, fs_cnt, err_cnt, err_cnt_b;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    pix_t p;
    if (pv_a) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL pixel_unexpected got x=%0d y=%0d, required no pixel", x_a, y_a);
      end else begin
        p = sb_q.pop_front();
        if ({x_a, y_a, ls_a, fs_a} !== {p.x, p.y, p.ls, p.fs}) begin
          miscompares++;
          $display("FAIL pixel got x=%0d y=%0d ls=%0b fs=%0b, required x=%0d y=%0d ls=%0b fs=%0b",
                   x_a, y_a, ls_a, fs_a, p.x, p.y, p.ls, p.fs);
        end
      end
    end
    if (pv_a) pv_cnt++;
    if (ls_a) ls_cnt++;
    if (fs_a) fs_cnt++;
    if (er_a) err_cnt++;
    if (er_b) err_cnt_b++;
  end

  task automatic drive_cycle(input logic h, input logic v, input logic e);
    vid_a.hsync = h;
    vid_a.vsync = v;
    vid_a.ve    = e;
    vid_b.hsync = ~h;
    vid_b.vsync = ~v;
    vid_b.ve    = e;
    @(posedge clock);
    #1;
  endtask

  // Frame of 10 lines: vsync lines 0-1, active lines 2-7, hsync 2 clocks, ve at cycles 4..15.
  task automatic gen_frame(input int htot, input int lo, input int hi);
    for (int l = 0; l < 10; l++) begin
      for (int c = 0; c < htot; c++) begin
        int   idx;
        logic e;
        pix_t p;
        idx = l * htot + c;
        if (idx >= lo && idx < hi) begin
          e = (l >= 2) && (l < 8) && (c >= 4) && (c < 16);
          if (e && exp_locked) begin
            p.x  = 12'(c - 4);
            p.y  = 12'(l - 2);
            p.ls = (c == 4);
            p.fs = (c == 4) && (l == 2);
            sb_q.push_back(p);
          end
          drive_cycle(c < 2, l < 2, e);
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    exp_locked = 1'b0;
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0);
    vectors++;
    if ({lk_a, er_a, pv_a, ls_a, fs_a} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b, required 00000", {lk_a, er_a, pv_a, ls_a, fs_a});
    end
    vectors++;
    if ({x_a, y_a} !== 24'd0) begin
      miscompares++;
      $display("FAIL reset_xy got x=%0d y=%0d, required 0 0", x_a, y_a);
    end
    vectors++;
    if ({ht_a, ha_a, vt_a, va_a} !== 48'd0) begin
      miscompares++;
      $display("FAIL reset_geom got %0d/%0d/%0d/%0d, required 0/0/0/0", ht_a, ha_a, vt_a, va_a);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_lock;
    err_cnt = 0;
    gen_frame(20, 0, 200);
    gen_frame(20, 0, 200);
    vectors++;
    if (lk_a !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_early got %b, required 0", lk_a);
    end
    gen_frame(20, 0, 1);
    vectors++;
    if (lk_a !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_latency1 got %b, required 0", lk_a);
    end
    gen_frame(20, 1, 2);
    vectors++;
    if (lk_a !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_latency2 got %b, required 1", lk_a);
    end
    vectors++;
    if ({ht_a, ha_a, vt_a, va_a} !== {12'd20, 12'd12, 12'd10, 12'd6}) begin
      miscompares++;
      $display("FAIL lock_geom got %0d/%0d/%0d/%0d, required 20/12/10/6", ht_a, ha_a, vt_a, va_a);
    end
    exp_locked = 1'b1;
    gen_frame(20, 2, 200);
    vectors++;
    if (err_cnt !== 0) begin
      miscompares++;
      $display("FAIL lock_error_count got %0d, required 0", err_cnt);
    end
  endtask

  task automatic test_polarity;
    vectors++;
    if (lk_b !== 1'b1) begin
      miscompares++;
      $display("FAIL pol_locked got %b, required 1", lk_b);
    end
    vectors++;
    if ({ht_b, ha_b, vt_b, va_b} !== {12'd20, 12'd12, 12'd10, 12'd6}) begin
      miscompares++;
      $display("FAIL pol_geom got %0d/%0d/%0d/%0d, required 20/12/10/6", ht_b, ha_b, vt_b, va_b);
    end
    vectors++;
    if (err_cnt_b !== 0) begin
      miscompares++;
      $display("FAIL pol_error_count got %0d, required 0", err_cnt_b);
    end
  endtask

  task automatic test_coords;
    pv_cnt = 0;
    ls_cnt = 0;
    fs_cnt = 0;
    gen_frame(20, 0, 200);
    vectors++;
    if (pv_cnt !== 72) begin
      miscompares++;
      $display("FAIL coord_pixel_count got %0d, required 72", pv_cnt);
    end
    vectors++;
    if (ls_cnt !== 6) begin
      miscompares++;
      $display("FAIL coord_line_starts got %0d, required 6", ls_cnt);
    end
    vectors++;
    if (fs_cnt !== 1) begin
      miscompares++;
      $display("FAIL coord_frame_starts got %0d, required 1", fs_cnt);
    end
  endtask

  task automatic test_geom_change;
    err_cnt = 0;
    gen_frame(21, 0, 210);
    exp_locked = 1'b0;
    gen_frame(21, 0, 1);
    vectors++;
    if ({er_a, lk_a} !== 2'b01) begin
      miscompares++;
      $display("FAIL chg_before got error=%b locked=%b, required 0 1", er_a, lk_a);
    end
    gen_frame(21, 1, 2);
    vectors++;
    if ({er_a, lk_a} !== 2'b10) begin
      miscompares++;
      $display("FAIL chg_detect got error=%b locked=%b, required 1 0", er_a, lk_a);
    end
    gen_frame(21, 2, 3);
    vectors++;
    if (er_a !== 1'b0) begin
      miscompares++;
      $display("FAIL chg_pulse_width got error=%b, required 0", er_a);
    end
    gen_frame(21, 3, 210);
    gen_frame(21, 0, 210);
    gen_frame(21, 0, 1);
    vectors++;
    if (lk_a !== 1'b0) begin
      miscompares++;
      $display("FAIL relock_early got %b, required 0", lk_a);
    end
    gen_frame(21, 1, 2);
    vectors++;
    if ({lk_a, ht_a} !== {1'b1, 12'd21}) begin
      miscompares++;
      $display("FAIL relock got locked=%b h_total=%0d, required 1 21", lk_a, ht_a);
    end
    exp_locked = 1'b1;
    gen_frame(21, 2, 210);
    vectors++;
    if (err_cnt !== 1) begin
      miscompares++;
      $display("FAIL chg_error_count got %0d, required 1", err_cnt);
    end
  endtask

  task automatic test_reset_mid_frame;
    gen_frame(21, 0, 31);
    reset = 1'b0;
    gen_frame(21, 31, 32);
    vectors++;
    if ({lk_a, er_a, pv_a, x_a, y_a, ht_a, va_a} !== 51'd0) begin
      miscompares++;
      $display("FAIL midreset got locked=%b x=%0d y=%0d h_total=%0d v_active=%0d, required all 0",
               lk_a, x_a, y_a, ht_a, va_a);
    end
    reset = 1'b1;
    exp_locked = 1'b0;
    gen_frame(21, 32, 210);
    gen_frame(21, 0, 210);
    gen_frame(21, 0, 210);
    gen_frame(21, 0, 1);
    vectors++;
    if (lk_a !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_relock_early got %b, required 0", lk_a);
    end
    gen_frame(21, 1, 2);
    vectors++;
    if ({lk_a, ht_a} !== {1'b1, 12'd21}) begin
      miscompares++;
      $display("FAIL midreset_relock got locked=%b h_total=%0d, required 1 21", lk_a, ht_a);
    end
    exp_locked = 1'b1;
    gen_frame(21, 2, 210);
  endtask

  task automatic test_saturation;
    reset = 1'b0;
    exp_locked = 1'b0;
    drive_cycle(1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) drive_cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5000; i++) drive_cycle(1'b0, 1'b0, 1'b0);
    gen_frame(20, 0, 200);
    vectors++;
    if (lk_a !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_no_lock1 got %b, required 0", lk_a);
    end
    gen_frame(20, 0, 200);
    vectors++;
    if (lk_a !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_no_lock2 got %b, required 0", lk_a);
    end
    gen_frame(20, 0, 2);
    vectors++;
    if ({lk_a, ht_a, ha_a, vt_a, va_a} !== {1'b1, 12'd20, 12'd12, 12'd10, 12'd6}) begin
      miscompares++;
      $display("FAIL sat_relock got locked=%b geom=%0d/%0d/%0d/%0d, required 1 20/12/10/6",
               lk_a, ht_a, ha_a, vt_a, va_a);
    end
    exp_locked = 1'b1;
    gen_frame(20, 2, 200);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    err_cnt     = 0;
    err_cnt_b   = 0;
    pv_cnt      = 0;
    ls_cnt      = 0;
    fs_cnt      = 0;
    exp_locked  = 1'b0;
    vid_a.hsync = 1'b0;
    vid_a.vsync = 1'b0;
    vid_a.ve    = 1'b0;
    vid_b.hsync = 1'b1;
    vid_b.vsync = 1'b1;
    vid_b.ve    = 1'b0;
    reset       = 1'b0;
    test_reset();
    test_lock();
    test_polarity();
    test_coords();
    test_geom_change();
    test_reset_mid_frame();
    test_saturation();
    vectors++;
    if (sb_q.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
